inst_mem_ctrl: RTL

INST_MEM_CTRL -- requirements
Module: inst_mem_ctrl

---
 rtl/inst_mem_ctrl_if.sv | 28 ++
 rtl/inst_mem_ctrl.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/inst_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_ctrl_if
// Description : Fetch-request and byte-RAM bus bundle for inst_mem_ctrl.
//               master = fetch stage + RAM side, slave = the controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_mem_ctrl_if;
    logic        rdy_in;
    logic        if_get;
    logic [31:0] if_pc;
    logic        inst_done;
    logic [31:0] inst_out;
    logic [7:0]  mem_din;
    logic [31:0] mem_a;
    logic        mem_wr;

    modport master (
        output rdy_in, if_get, if_pc, mem_din,
        input  inst_done, inst_out, mem_a, mem_wr
    );

    modport slave (
        input  rdy_in, if_get, if_pc, mem_din,
        output inst_done, inst_out, mem_a, mem_wr
    );
endinterface
`default_nettype wire

// File: rtl/inst_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_ctrl
// Description : Fetches a 32-bit little-endian instruction as four byte reads
//               from an 8-bit RAM with one cycle of read latency. A fetch is
//               abandoned when the request drops or its address changes, and
//               restarted from its first byte after any global stall.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_ctrl (
    input  wire              clk_in,
    input  wire              rst_in,
    inst_mem_ctrl_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t      r_state,     w_state_nxt;
    logic [31:0] r_addr,      w_addr_nxt;
    logic [31:0] r_mem_a,     w_mem_a_nxt;
    logic [2:0]  r_issue,     w_issue_nxt;
    logic [2:0]  r_rcnt,      w_rcnt_nxt;
    logic [23:0] r_buf,       w_buf_nxt;
    logic        r_inst_done, w_inst_done_nxt;
    logic [31:0] r_inst_out,  w_inst_out_nxt;
    logic        r_restart,   w_restart_nxt;

    logic        w_abort;

    // The requester withdrew the fetch or moved to a different address.
    assign w_abort = !bus.if_get || (bus.if_pc != r_addr);

    // Next-state and datapath decisions; everything holds while rdy_in is low.
    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_mem_a_nxt     = r_mem_a;
        w_issue_nxt     = r_issue;
        w_rcnt_nxt      = r_rcnt;
        w_buf_nxt       = r_buf;
        w_inst_done_nxt = r_inst_done;
        w_inst_out_nxt  = r_inst_out;
        w_restart_nxt   = r_restart;

        if (bus.rdy_in) begin
            case (r_state)
                S_IDLE: begin
                    if (bus.if_get) begin
                        w_state_nxt = S_FETCH;
                        w_addr_nxt  = bus.if_pc;
                        w_mem_a_nxt = bus.if_pc;
                        w_issue_nxt = 3'd0;
                        w_rcnt_nxt  = 3'd0;
                        w_buf_nxt   = 24'd0;
                    end
                end
                S_FETCH: begin
                    if (w_abort) begin
                        w_state_nxt   = S_IDLE;
                        w_issue_nxt   = 3'd0;
                        w_rcnt_nxt    = 3'd0;
                        w_restart_nxt = 1'b0;
                    end else if (r_restart) begin
                        // Bytes seen before the stall are untrusted: start over.
                        w_addr_nxt    = bus.if_pc;
                        w_mem_a_nxt   = bus.if_pc;
                        w_issue_nxt   = 3'd0;
                        w_rcnt_nxt    = 3'd0;
                        w_restart_nxt = 1'b0;
                    end else begin
                        if (r_issue < 3'd3) begin
                            w_mem_a_nxt = r_mem_a + 32'd1;
                        end
                        w_issue_nxt = r_issue + 3'd1;
                        // Read data trails the address by one cycle, so the
                        // first FETCH edge has nothing to capture yet.
                        if (r_issue != 3'd0) begin
                            w_rcnt_nxt = r_rcnt + 3'd1;
                            case (r_rcnt)
                                3'd0: w_buf_nxt[7:0]   = bus.mem_din;
                                3'd1: w_buf_nxt[15:8]  = bus.mem_din;
                                3'd2: w_buf_nxt[23:16] = bus.mem_din;
                                3'd3: begin
                                    w_inst_out_nxt  = {bus.mem_din, r_buf};
                                    w_inst_done_nxt = 1'b1;
                                    w_state_nxt     = S_DONE;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_DONE: begin
                    w_inst_done_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end else if (r_state == S_FETCH) begin
            w_restart_nxt = 1'b1;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= S_IDLE;
            r_addr      <= 32'd0;
            r_mem_a     <= 32'd0;
            r_issue     <= 3'd0;
            r_rcnt      <= 3'd0;
            r_buf       <= 24'd0;
            r_inst_done <= 1'b0;
            r_inst_out  <= 32'd0;
            r_restart   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_mem_a     <= w_mem_a_nxt;
            r_issue     <= w_issue_nxt;
            r_rcnt      <= w_rcnt_nxt;
            r_buf       <= w_buf_nxt;
            r_inst_done <= w_inst_done_nxt;
            r_inst_out  <= w_inst_out_nxt;
            r_restart   <= w_restart_nxt;
        end
    end

    assign bus.inst_done = r_inst_done;
    assign bus.inst_out  = r_inst_out;
    assign bus.mem_a     = r_mem_a;
    assign bus.mem_wr    = 1'b0;

endmodule
`default_nettype wire
